ik_leg_scheduler: RTL and testbench

IK_LEG_SCHEDULER -- requirements
Module: ik_leg_scheduler

---
 rtl/ik_sched_pkg.sv | 17 +
 rtl/leg_priority_enc.sv | 23 ++
 rtl/ik_leg_scheduler.sv | 145 ++++++++++++++
 tb/tb_ik_leg_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ik_sched_pkg.sv
// Shared types and defaults for the IK leg scheduler: FSM state encoding,
// default leg count, watchdog limit and watchdog counter width.
package ik_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_t;

    localparam int DEF_N_LEGS         = 6;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int WD_CNT_W           = 8;

endpackage

// File: rtl/leg_priority_enc.sv
// Combinational lowest-set-bit encoder used to choose the next leg to solve.
module leg_priority_enc #(
    parameter int N_LEGS = 6,
    parameter int IDX_W  = $clog2(N_LEGS)
)(
    input  logic [N_LEGS-1:0] mask,
    output logic [IDX_W-1:0]  index,
    output logic              any
);

    always_comb begin
        index = '0;
        // Scanning downwards lets the lowest set bit overwrite any higher one.
        for (int i = N_LEGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = i[IDX_W-1:0];
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/ik_leg_scheduler.sv
// Sequences a batch of legs through one shared IK core in ascending index order.
// Optional WAIT watchdog is compiled in when IK_SCHED_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for START; mask latched on acceptance
// SELECT | pick lowest pending leg, or finish when none left
// ISSUE  | CORE_START held until CORE_READY
// WAIT   | waiting for CORE_DONE (or watchdog expiry)
// FINISH | one-cycle BATCH_DONE pulse
module ik_leg_scheduler
    import ik_sched_pkg::*;
#(
    parameter int N_LEGS         = DEF_N_LEGS,
    parameter int N_LEGS_SIZE    = $clog2(N_LEGS),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic [N_LEGS-1:0]      LEG_MASK,
    input  logic                   CORE_READY,
    input  logic                   CORE_DONE,
    output logic                   CORE_START,
    output logic [N_LEGS_SIZE-1:0] CORE_LEG_SEL,
    output logic                   BUSY,
    output logic                   BATCH_DONE,
    output logic [N_LEGS-1:0]      LEG_DONE_MASK,
    output logic                   TIMEOUT
);

    sched_state_t state_q, state_d;

    logic [N_LEGS-1:0]      pending_q;
    logic [N_LEGS-1:0]      done_mask_q;
    logic [N_LEGS_SIZE-1:0] leg_sel_q;
    logic [N_LEGS_SIZE-1:0] pick_idx;
    logic                   pick_any;
    logic                   start_accept;
    logic                   leg_retire;

    leg_priority_enc #(
        .N_LEGS (N_LEGS),
        .IDX_W  (N_LEGS_SIZE)
    ) u_prio (
        .mask  (pending_q),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign start_accept = (state_q == ST_IDLE) && START && !ABORT;

`ifdef IK_SCHED_TIMEOUT_EN
    localparam logic [WD_CNT_W-1:0] WD_LIMIT = WD_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WD_CNT_W-1:0] wd_cnt_q;
    logic                timeout_q;
    logic                wd_expire;

    // CORE_DONE on the limit cycle wins, so expiry requires its absence.
    assign wd_expire  = (state_q == ST_WAIT) && !CORE_DONE && (wd_cnt_q == WD_LIMIT);
    assign leg_retire = (state_q == ST_WAIT) && (CORE_DONE || wd_expire);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE && CORE_READY) begin
                wd_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (start_accept) begin
                timeout_q <= 1'b0;
            end else if (wd_expire && !ABORT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign TIMEOUT = timeout_q;
`else
    logic unused_timeout_cfg;

    assign leg_retire         = (state_q == ST_WAIT) && CORE_DONE;
    assign TIMEOUT            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (START) state_d = ST_SELECT;
            ST_SELECT: state_d = pick_any ? ST_ISSUE : ST_FINISH;
            ST_ISSUE:  if (CORE_READY) state_d = ST_WAIT;
            ST_WAIT:   if (leg_retire) state_d = ST_SELECT;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (ABORT) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q   <= '0;
            done_mask_q <= '0;
            leg_sel_q   <= '0;
        end else if (ABORT) begin
            pending_q <= '0;
        end else begin
            if (start_accept) begin
                pending_q   <= LEG_MASK;
                done_mask_q <= '0;
            end
            if (state_q == ST_SELECT && pick_any) begin
                leg_sel_q <= pick_idx;
            end
            // A watchdog-retired leg leaves pending without being marked done.
            if (leg_retire) begin
                pending_q[leg_sel_q] <= 1'b0;
                if (CORE_DONE) begin
                    done_mask_q[leg_sel_q] <= 1'b1;
                end
            end
        end
    end

    assign CORE_START    = (state_q == ST_ISSUE);
    assign BUSY          = (state_q != ST_IDLE);
    assign BATCH_DONE    = (state_q == ST_FINISH);
    assign CORE_LEG_SEL  = leg_sel_q;
    assign LEG_DONE_MASK = done_mask_q;

endmodule

// File: tb/tb_ik_leg_scheduler.sv
// Self-checking bench for ik_leg_scheduler; issued legs are checked against a
// scoreboard queue filled from each batch mask. Covers IK_SCHED_TIMEOUT_EN when defined.
module tb_ik_leg_scheduler;

`ifdef IK_SCHED_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [5:0] LEG_MASK = '0;
    logic       CORE_READY = 1'b0;
    logic       CORE_DONE = 1'b0;
    logic       CORE_START;
    logic [2:0] CORE_LEG_SEL;
    logic       BUSY;
    logic       BATCH_DONE;
    logic [5:0] LEG_DONE_MASK;
    logic       TIMEOUT;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb_q[$];

    ik_leg_scheduler #(
        .N_LEGS         (6),
        .N_LEGS_SIZE    (3),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .START         (START),
        .ABORT         (ABORT),
        .LEG_MASK      (LEG_MASK),
        .CORE_READY    (CORE_READY),
        .CORE_DONE     (CORE_DONE),
        .CORE_START    (CORE_START),
        .CORE_LEG_SEL  (CORE_LEG_SEL),
        .BUSY          (BUSY),
        .BATCH_DONE    (BATCH_DONE),
        .LEG_DONE_MASK (LEG_DONE_MASK),
        .TIMEOUT       (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, CORE_START, BATCH_DONE, TIMEOUT} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/start/bdone/to=%b expected 0000",
                     {BUSY, CORE_START, BATCH_DONE, TIMEOUT});
        end
        checks++;
        if (CORE_LEG_SEL !== 3'd0 || LEG_DONE_MASK !== 6'd0) begin
            errors++;
            $display("FAIL reset_data: got sel=%0d done=%b expected sel=0 done=000000",
                     CORE_LEG_SEL, LEG_DONE_MASK);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b expected 0", BUSY);
        end
    endtask

    // Runs one batch with a responsive core model; stalls = CORE_READY low cycles per issue.
    task automatic run_batch(input logic [5:0] mask, input int stalls, input bit no_done,
                             input string name);
        int         cyc, exp_cyc, nlegs, start_len, first_start;
        bit         done_next, finished;
        logic [2:0] sel_hold, exp_leg;
        logic [5:0] exp_done;

        nlegs = 0;
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) begin
                sb_q.push_back(i[2:0]);
                nlegs++;
            end
        end
        exp_done    = no_done ? 6'd0 : mask;
        exp_cyc     = no_done ? nlegs * (stalls + 2 + TO_CYC) + 2 : nlegs * (stalls + 3) + 2;
        start_len   = 0;
        first_start = -1;
        done_next   = 1'b0;
        finished    = 1'b0;
        sel_hold    = '0;

        LEG_MASK   = mask;
        START      = 1'b1;
        CORE_READY = 1'b0;
        CORE_DONE  = 1'b0;
        @(negedge CLK);
        START    = 1'b0;
        LEG_MASK = 6'($urandom);
        cyc      = 1;

        while (cyc <= 400) begin
            CORE_DONE = done_next && !no_done;
            done_next = 1'b0;
            if (BATCH_DONE) begin
                finished = 1'b1;
                checks++;
                if (cyc != exp_cyc) begin
                    errors++;
                    $display("FAIL %s batch_done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
                end
                break;
            end
            if (CORE_START) begin
                start_len++;
                if (start_len == 1) begin
                    if (first_start < 0) first_start = cyc;
                    sel_hold = CORE_LEG_SEL;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s unexpected_issue: got leg %0d expected none", name, CORE_LEG_SEL);
                    end else begin
                        exp_leg = sb_q.pop_front();
                        if (CORE_LEG_SEL !== exp_leg) begin
                            errors++;
                            $display("FAIL %s issue_order: got leg %0d expected %0d",
                                     name, CORE_LEG_SEL, exp_leg);
                        end
                    end
                end else begin
                    checks++;
                    if (CORE_LEG_SEL !== sel_hold) begin
                        errors++;
                        $display("FAIL %s sel_stable: got %0d expected %0d", name, CORE_LEG_SEL, sel_hold);
                    end
                end
                CORE_READY = (start_len > stalls);
                if (CORE_READY) done_next = 1'b1;
                else            CORE_DONE = 1'b1;
            end else begin
                if (start_len > 0) begin
                    checks++;
                    if (start_len != stalls + 1) begin
                        errors++;
                        $display("FAIL %s start_len: got %0d expected %0d", name, start_len, stalls + 1);
                    end
                    start_len = 0;
                end
                CORE_READY = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end

        if (!finished) begin
            errors++;
            $display("FAIL %s batch_timeout: got no BATCH_DONE expected one by cycle %0d", name, exp_cyc);
        end
        checks++;
        if (first_start != (nlegs > 0 ? 2 : -1)) begin
            errors++;
            $display("FAIL %s first_start: got cycle %0d expected %0d", name, first_start,
                     nlegs > 0 ? 2 : -1);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s legs_missing: got %0d unissued expected 0", name, sb_q.size());
            sb_q.delete();
        end
        checks++;
        if (LEG_DONE_MASK !== exp_done) begin
            errors++;
            $display("FAIL %s done_mask: got %b expected %b", name, LEG_DONE_MASK, exp_done);
        end
        checks++;
        if (TIMEOUT !== no_done) begin
            errors++;
            $display("FAIL %s timeout_flag: got %b expected %b", name, TIMEOUT, no_done);
        end
        CORE_DONE  = 1'b0;
        CORE_READY = 1'b0;
        @(negedge CLK);
        checks++;
        if (BATCH_DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s after_finish: got bdone=%b busy=%b expected 0 0", name, BATCH_DONE, BUSY);
        end
    endtask

    task automatic test_abort();
        sb_q.push_back(3'd0);
        sb_q.push_back(3'd1);
        LEG_MASK   = 6'b000111;
        START      = 1'b1;
        CORE_READY = 1'b1;
        @(negedge CLK);               // cycle 1: SELECT
        START = 1'b0;
        @(negedge CLK);               // cycle 2: ISSUE leg 0, START here must be ignored
        checks++;
        if (CORE_START !== 1'b1 || CORE_LEG_SEL !== sb_q.pop_front()) begin
            errors++;
            $display("FAIL abort_leg0: got start=%b sel=%0d expected 1 0", CORE_START, CORE_LEG_SEL);
        end
        START    = 1'b1;
        LEG_MASK = 6'b111000;
        @(negedge CLK);               // cycle 3: WAIT leg 0
        START     = 1'b0;
        CORE_DONE = 1'b1;
        @(negedge CLK);               // cycle 4: SELECT
        CORE_DONE = 1'b0;
        @(negedge CLK);               // cycle 5: ISSUE leg 1
        checks++;
        if (CORE_START !== 1'b1 || CORE_LEG_SEL !== sb_q.pop_front()) begin
            errors++;
            $display("FAIL abort_leg1: got start=%b sel=%0d expected 1 1", CORE_START, CORE_LEG_SEL);
        end
        @(negedge CLK);               // cycle 6: WAIT leg 1, abort beats done and start
        ABORT     = 1'b1;
        CORE_DONE = 1'b1;
        START     = 1'b1;
        LEG_MASK  = 6'b000111;
        @(negedge CLK);
        ABORT      = 1'b0;
        CORE_DONE  = 1'b0;
        START      = 1'b0;
        CORE_READY = 1'b0;
        checks++;
        if ({BUSY, CORE_START, BATCH_DONE} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: got busy/start/bdone=%b expected 000", {BUSY, CORE_START, BATCH_DONE});
        end
        checks++;
        if (LEG_DONE_MASK !== 6'b000001) begin
            errors++;
            $display("FAIL abort_done_mask: got %b expected 000001", LEG_DONE_MASK);
        end
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || BATCH_DONE !== 1'b0) begin
                errors++;
                $display("FAIL abort_stays_idle: got busy=%b bdone=%b expected 0 0", BUSY, BATCH_DONE);
            end
        end
        run_batch(6'b000111, 0, 1'b0, "abort_restart");
    endtask

    task automatic test_async_reset();
        LEG_MASK   = 6'b000100;
        START      = 1'b1;
        CORE_READY = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);               // ISSUE for leg 2, core not ready
        checks++;
        if (CORE_START !== 1'b1 || CORE_LEG_SEL !== 3'd2) begin
            errors++;
            $display("FAIL arst_pre: got start=%b sel=%0d expected 1 2", CORE_START, CORE_LEG_SEL);
        end
        #1 RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, CORE_START, BATCH_DONE} !== 3'b000 || CORE_LEG_SEL !== 3'd0) begin
            errors++;
            $display("FAIL arst_async: got busy/start/bdone=%b sel=%0d expected 000 0",
                     {BUSY, CORE_START, BATCH_DONE}, CORE_LEG_SEL);
        end
        #1 RST = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || BATCH_DONE !== 1'b0 || CORE_START !== 1'b0) begin
                errors++;
                $display("FAIL arst_needs_start: got busy=%b bdone=%b start=%b expected 0 0 0",
                         BUSY, BATCH_DONE, CORE_START);
            end
        end
    endtask

    initial begin
        test_reset();
        run_batch(6'b111111, 0, 1'b0, "full_batch");
        run_batch(6'b100100, 3, 1'b0, "sparse_backpressure");
        run_batch(6'b000000, 0, 1'b0, "empty_mask");
        test_abort();
        run_batch(6'b010011, 1, 1'b0, "back_to_back_a");
        run_batch(6'b101010, 2, 1'b0, "back_to_back_b");
`ifdef IK_SCHED_TIMEOUT_EN
        run_batch(6'b001000, 0, 1'b1, "watchdog");
        run_batch(6'b000001, 0, 1'b0, "watchdog_clear");
`endif
        test_async_reset();
        run_batch(6'b100001, 1, 1'b0, "post_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
